// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit: MEM-stage load/store sequencer on a single-beat 64-bit   |
// | request/ready data port, with alignment, illegal-op and timeout faults.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_readMem,
  input  logic        me_writeMem,
  input  logic [2:0]  me_memOp,
  input  logic [63:0] me_outAlu,
  input  logic [63:0] me_rs2Data,
  output logic        mem_stall,
  output logic [63:0] me_memOut,
  output logic        me_memFault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_REQ     = 2'd1;
  localparam logic [1:0]  S_DONE    = 2'd2;
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] wait_cnt;
  logic        access;
  logic        illegal;
  logic        misaligned;
  logic        bad;
  logic        timeout;
  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [63:0] lane;
  logic [63:0] load_val;

  assign access = me_readMem | me_writeMem;
  assign off    = me_outAlu[2:0];

  always_comb begin
    illegal = 1'b0;
    if (me_readMem && me_writeMem) begin
      illegal = 1'b1;
    end else if (me_readMem) begin
      illegal = (me_memOp == 3'b111);
    end else if (me_writeMem) begin
      illegal = me_memOp[2];
    end
  end

  // Access size is funct3[1:0] for both loads and stores (including unsigned loads).
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'hFF;
    case (me_memOp[1:0])
      2'd0: begin
        misaligned = 1'b0;
        size_mask  = 8'h01;
      end
      2'd1: begin
        misaligned = off[0];
        size_mask  = 8'h03;
      end
      2'd2: begin
        misaligned = |off[1:0];
        size_mask  = 8'h0F;
      end
      default: begin
        misaligned = |off;
        size_mask  = 8'hFF;
      end
    endcase
  end

  assign bad     = access & (illegal | misaligned);
  assign timeout = (state == S_REQ) && !dmem_ready && (wait_cnt == C_TO_LAST);

  assign lane = dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (me_memOp)
      3'b000:  load_val = {{56{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_val = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_val = {56'd0, lane[7:0]};
      3'b101:  load_val = {48'd0, lane[15:0]};
      3'b110:  load_val = {32'd0, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = (access && !bad) ? S_REQ : S_IDLE;
      S_REQ:   state_nxt = (dmem_ready || timeout) ? S_DONE : S_REQ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus controls in REQ follow the me_* inputs directly; the stall keeps them stable.
  always_comb begin
    mem_stall  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_wstrb = 8'h00;
    case (state)
      S_IDLE: begin
        mem_stall = access && !bad;
      end
      S_REQ: begin
        mem_stall  = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = me_writeMem;
        dmem_wstrb = me_writeMem ? (size_mask << off) : 8'h00;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  assign dmem_addr  = {me_outAlu[63:3], 3'b000};
  assign dmem_wdata = me_rs2Data << {off, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= 16'd0;
      me_memOut   <= 64'd0;
      me_memFault <= 1'b0;
    end else begin
      me_memFault <= ((state == S_IDLE) && bad) || timeout;
      if (state == S_REQ) begin
        if (dmem_ready) begin
          wait_cnt <= 16'd0;
          if (me_readMem) begin
            me_memOut <= load_val;
          end
        end else if (timeout) begin
          wait_cnt <= 16'd0;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end else begin
        wait_cnt <= 16'd0;
      end
    end
  end

endmodule
`default_nettype wire
